muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU, with architectural HI/LO registers, MFHI/MFLO read-out and MTHI/MTLO writes.
- Sits downstream of the PC/instruction-memory/register-file datapath and consumes its SrcA and WriteData (used as SrcB) outputs.
- The controller stalls PC update while busy=1.
- The result reaches the register file through the existing Result write-back mux.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the controller/datapath and the muldiv unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             HiWrite;
    logic             LoWrite;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, SrcA, SrcB, HiWrite, LoWrite,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, SrcA, SrcB, HiWrite, LoWrite,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO: shift-add multiply, restoring divide,
// one bit per cycle on magnitudes, sign correction applied when the result is written.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
        return n ? (WIDTH'(0) - x) : x;
    endfunction

    function automatic logic [W2-1:0] cond_neg2(input logic [W2-1:0] x, input logic n);
        return n ? (W2'(0) - x) : x;
    endfunction

    state_e             r_state;
    state_e             w_next;
    op_e                r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [CNT_W-1:0]   r_cnt;
    logic [W2-1:0]      r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    op_e                w_op_in;
    logic               w_signed_in;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH:0]     w_diff;
    logic [W2-1:0]      w_step;
    logic [W2-1:0]      w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_op_in     = op_e'(bus.op);
    assign w_signed_in = ~bus.op[0];
    assign w_sa        = w_signed_in & bus.SrcA[WIDTH-1];
    assign w_sb        = w_signed_in & bus.SrcB[WIDTH-1];
    assign w_mag_a     = cond_neg(bus.SrcA, w_sa);
    assign w_mag_b     = cond_neg(bus.SrcB, w_sb);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left.
    assign w_msum = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, r_a};
    assign w_rsh  = r_acc[W2-1:WIDTH-1];
    assign w_diff = w_rsh - {1'b0, r_b};

    always_comb begin
        w_step = r_acc;
        if (r_op == OP_DIV || r_op == OP_DIVU) begin
            if (w_diff[WIDTH])
                w_step = {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            else
                w_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            if (r_acc[0])
                w_step = {w_msum, r_acc[WIDTH-1:1]};
            else
                w_step = {1'b0, r_acc[W2-1:1]};
        end
    end

    // A zero divisor leaves the dividend magnitude as remainder, so the normal
    // remainder sign fix already restores the raw SrcA; only LO needs forcing.
    assign w_prod = cond_neg2(r_acc, r_neg_q);
    assign w_quo  = (r_b == '0) ? '1 : cond_neg(r_acc[WIDTH-1:0], r_neg_q);
    assign w_rem  = cond_neg(r_acc[W2-1:WIDTH], r_neg_r);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (r_cnt == '0) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_cnt <= CNT_W'(WIDTH - 1);
        end else if (r_state == RUN && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && bus.start) begin
            r_op    <= w_op_in;
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            if (bus.op[1])
                r_acc <= {{WIDTH{1'b0}}, w_mag_a};
            else
                r_acc <= {{WIDTH{1'b0}}, w_mag_b};
        end else if (r_state == RUN) begin
            r_acc <= w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == FINISH);
            if (r_state == FINISH) begin
                if (r_op == OP_DIV || r_op == OP_DIVU) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[W2-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end else if (r_state == IDLE) begin
                if (bus.HiWrite) r_hi <= bus.SrcA;
                if (bus.LoWrite) r_lo <= bus.SrcA;
            end
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, control corner cases and
// randomized operations against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sp, sq, sr;
        longint unsigned up;
        logic [63:0]     v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (o)
            2'b00: begin
                sp = sa * sb;
                v  = sp;
                hi = v[63:32];
                lo = v[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                v  = up;
                hi = v[63:32];
                lo = v[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    v  = sq;
                    lo = v[31:0];
                    v  = sr;
                    hi = v[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.SrcA  = a;
        bus.SrcB  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
    endtask

    // Called #1 after the start edge; returns cycles until done is seen (capped).
    task automatic wait_done(output int lat, output int nbusy, output bit held);
        logic [31:0] hi0, lo0;
        hi0   = bus.HI;
        lo0   = bus.LO;
        held  = 1'b1;
        lat   = 0;
        nbusy = bus.busy ? 1 : 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
            if (bus.busy) nbusy++;
            if (bus.HI !== hi0 || bus.LO !== lo0) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b HI=%h LO=%h, required 0/0/0/0",
                     bus.busy, bus.done, bus.HI, bus.LO);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [31:0] ehs [6];
        logic [31:0] els [6];
        int lat, nbusy;
        bit held;
        ops = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
        as  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h0000_1234, 32'h8000_0000};
        bs  = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        ehs = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'h0000_1234, 32'd0};
        els = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, nbusy, held);
            n_cmp++;
            if (lat !== 33 || nbusy !== 33 || !held) begin
                n_err++;
                $display("FAIL directed%0d_timing: latency=%0d busy_cycles=%0d held=%b, required 33/33/1",
                         i, lat, nbusy, held);
            end
            n_cmp++;
            if (bus.HI !== ehs[i] || bus.LO !== els[i]) begin
                n_err++;
                $display("FAIL directed%0d_result: HI=%h LO=%h, required HI=%h LO=%h",
                         i, bus.HI, bus.LO, ehs[i], els[i]);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d_done_pulse: done=%b busy=%b after one cycle, required 0/0",
                         i, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_control();
        logic [31:0] eh, el, hi_before;
        int lat, nbusy;
        bit held;
        model(2'b01, 32'h0001_0003, 32'h0002_0005, eh, el);
        hi_before = bus.HI;
        issue(2'b01, 32'h0001_0003, 32'h0002_0005);
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.HiWrite = 1'b1;
        bus.SrcA    = 32'hAABB_CCDD;
        repeat (5) @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.HiWrite = 1'b0;
        n_cmp++;
        if (bus.HI !== hi_before) begin
            n_err++;
            $display("FAIL hiwrite_busy: HI=%h, required %h", bus.HI, hi_before);
        end
        wait_done(lat, nbusy, held);
        n_cmp++;
        if (lat !== 28 || bus.HI !== eh || bus.LO !== el) begin
            n_err++;
            $display("FAIL start_while_busy: latency=%0d HI=%h LO=%h, required 28 %h %h",
                     lat, bus.HI, bus.LO, eh, el);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL no_queue: busy=%b, required 0", bus.busy);
        end
        bus.HiWrite = 1'b1;
        bus.SrcA    = 32'hAABB_CCDD;
        @(posedge clk);
        #1;
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b1;
        bus.SrcA    = 32'h1122_3344;
        n_cmp++;
        if (bus.HI !== 32'hAABB_CCDD) begin
            n_err++;
            $display("FAIL hiwrite_idle: HI=%h, required aabbccdd", bus.HI);
        end
        @(posedge clk);
        #1;
        bus.LoWrite = 1'b0;
        n_cmp++;
        if (bus.LO !== 32'h1122_3344 || bus.HI !== 32'hAABB_CCDD) begin
            n_err++;
            $display("FAIL lowrite_idle: HI=%h LO=%h, required aabbccdd 11223344", bus.HI, bus.LO);
        end
        model(2'b00, 32'h0000_0BAD, 32'hFFFF_FF00, eh, el);
        bus.HiWrite = 1'b1;
        issue(2'b00, 32'h0000_0BAD, 32'hFFFF_FF00);
        bus.HiWrite = 1'b0;
        n_cmp++;
        if (bus.HI !== 32'h0000_0BAD || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_with_mthi: HI=%h busy=%b, required 00000bad 1", bus.HI, bus.busy);
        end
        wait_done(lat, nbusy, held);
        n_cmp++;
        if (lat !== 33 || bus.HI !== eh || bus.LO !== el) begin
            n_err++;
            $display("FAIL start_with_mthi_result: latency=%0d HI=%h LO=%h, required 33 %h %h",
                     lat, bus.HI, bus.LO, eh, el);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] eh, el;
        int lat, nbusy, seen;
        bit held;
        issue(2'b11, 32'hDEAD_BEEF, 32'd13);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b HI=%h LO=%h, required 0/0/0/0",
                     bus.busy, bus.done, bus.HI, bus.LO);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: done pulses=%0d, required 0", seen);
        end
        model(2'b11, 32'd1000, 32'd33, eh, el);
        issue(2'b11, 32'd1000, 32'd33);
        wait_done(lat, nbusy, held);
        n_cmp++;
        if (lat !== 33 || bus.HI !== eh || bus.LO !== el) begin
            n_err++;
            $display("FAIL reset_mid_restart: latency=%0d HI=%h LO=%h, required 33 %h %h",
                     lat, bus.HI, bus.LO, eh, el);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'(signed'($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        int lat, nbusy;
        bit held;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            model(o, a, b, eh, el);
            issue(o, a, b);
            wait_done(lat, nbusy, held);
            n_cmp++;
            if (lat !== 33 || !held || bus.HI !== eh || bus.LO !== el) begin
                n_err++;
                $display("FAIL random%0d op=%0d a=%h b=%h: latency=%0d held=%b HI=%h LO=%h, required 33 1 %h %h",
                         i, o, a, b, lat, held, bus.HI, bus.LO, eh, el);
            end
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.SrcA    = '0;
        bus.SrcB    = '0;
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_control();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
